// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register carrying a control bundle and a
// data bundle with a valid/ready handshake. It supports back-pressure,
// synchronous flush, and an optional two-entry skid buffer.
//
// Bubbles always present all-zero control, so the next stage sees a NOP.
//
// State (SKID=1) | meaning
// ---------------+-------------------------------------------------------
// EMPTY          | nothing held (m_valid=0, s_valid=0)
// FULL           | main entry presented (m_valid=1, s_valid=0)
// SKIDDED        | main presented, skid holds the next entry (both valid)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous kill of held entries and of the incoming transfer
//   in_valid   upstream entry present
//   in_ready   stage can accept this cycle (a flop when SKID=1)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  entry presented downstream
//   out_ready  downstream accepts this cycle
//   out_ctrl   control bundle, zero whenever out_valid=0
//   out_data   data bundle, don't-care when out_valid=0
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = m_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Encoding chosen so bit 0 is m_valid and bit 1 is s_valid; both
      // valids, and therefore in_ready, come straight from flops.
      typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FULL    = 2'b01,
        SKIDDED = 2'b11
      } state_t;

      state_t            state;
      logic              s_valid;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state  <= EMPTY;
          m_ctrl <= '0;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          state <= EMPTY;
        end else begin
          case (state)
            EMPTY: begin
              if (in_xfer) begin
                state  <= FULL;
                m_ctrl <= in_ctrl;
                m_data <= in_data;
              end
            end
            FULL: begin
              if (in_xfer && out_xfer) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
              end else if (in_xfer) begin
                state  <= SKIDDED;
                s_ctrl <= in_ctrl;
                s_data <= in_data;
              end else if (out_xfer) begin
                state <= EMPTY;
              end
            end
            SKIDDED: begin
              // in_ready is low here, so no input transfer can occur.
              if (out_xfer) begin
                state  <= FULL;
                m_ctrl <= s_ctrl;
                m_data <= s_data;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

      assign m_valid  = state[0];
      assign s_valid  = state[1];
      assign in_ready = ~s_valid;
    end else begin : g_noskid
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
        end else if (flush) begin
          m_valid <= 1'b0;
        end else if (in_xfer) begin
          m_valid <= 1'b1;
          m_ctrl  <= in_ctrl;
          m_data  <= in_data;
        end else if (out_xfer) begin
          m_valid <= 1'b0;
        end
      end

      assign in_ready = out_ready | ~m_valid;
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid. It uses three instances: the
// default skid configuration, SKID=0, and SKID=1 with CNT_W=4.
module tb_pipe_stage_skid;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Instance a: defaults (SKID=1)
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_stall_cnt;

  // Instance b: SKID=0
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_stall_cnt;

  // Instance c: SKID=1, CNT_W=4
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_in_ctrl, c_out_ctrl;
  logic [31:0] c_in_data, c_out_data;
  logic [3:0]  c_stall_cnt;

  pipe_stage_skid dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_skid #(.SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  pipe_stage_skid #(.SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .stall_cnt(c_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h expected 0", a_out_valid); end
    checks++; if (a_out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got %0h expected 0", a_out_ctrl); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %0h expected 0", a_out_data); end
    checks++; if (a_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %0h expected 0", a_stall_cnt); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %0h expected 0", b_out_valid); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 32'(i + 1);
      a_in_ctrl = 8'(8'h10 + i);
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h expected 1", i, a_out_valid); end
      checks++; if (a_out_data !== 32'(i + 1)) begin errors++; $display("FAIL stream_data[%0d] got %0h expected %0h", i, a_out_data, i + 1); end
      checks++; if (a_out_ctrl !== 8'(8'h10 + i)) begin errors++; $display("FAIL stream_ctrl[%0d] got %0h expected %0h", i, a_out_ctrl, 8'h10 + i); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0h expected 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0h expected 0", a_out_valid); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt got %0d expected 0", a_stall_cnt); end
  endtask

  task automatic test_skid_capture();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    a_in_ctrl   = 8'h0A;
    tick();
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL skid_first got %0h expected a", a_out_data); end
    // Stall begins while 0xA is presented; 0xB still enters (into the skid).
    a_out_ready = 1'b0;
    a_in_data   = 32'hB;
    a_in_ctrl   = 8'h0B;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_same_cycle got %0h expected 1", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_next got %0h expected 0", a_in_ready); end
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL skid_hold1 got %0h expected a", a_out_data); end
    a_in_data = 32'hC;
    a_in_ctrl = 8'h0C;
    tick();
    tick();
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL skid_hold3 got %0h expected a", a_out_data); end
    checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("FAIL skid_stall_cnt got %0d expected 3", a_stall_cnt); end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_data !== 32'hB) begin errors++; $display("FAIL skid_second got %0h expected b", a_out_data); end
    checks++; if (a_out_ctrl !== 8'h0B) begin errors++; $display("FAIL skid_second_ctrl got %0h expected b", a_out_ctrl); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %0h expected 1", a_in_ready); end
    tick();
    checks++; if (a_out_data !== 32'hC) begin errors++; $display("FAIL skid_third got %0h expected c", a_out_data); end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL skid_no_dup got %0h expected 0", a_out_valid); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h11;
    a_in_ctrl   = 8'h11;
    tick();
    a_out_ready = 1'b0;
    a_in_data   = 32'h22;
    a_in_ctrl   = 8'h22;
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_skidded got %0h expected 0", a_in_ready); end
    a_flush   = 1'b1;
    a_in_data = 32'h33;
    a_in_ctrl = 8'h33;
    tick();
    a_flush = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h expected 0", a_out_valid); end
    checks++; if (a_out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %0h expected 0", a_out_ctrl); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0h expected 1", a_in_ready); end
    checks++; if (a_stall_cnt !== 16'd5) begin errors++; $display("FAIL flush_stall_cnt got %0d expected 5", a_stall_cnt); end
    a_out_ready = 1'b1;
    a_in_data   = 32'h44;
    a_in_ctrl   = 8'h44;
    tick();
    checks++; if (a_out_data !== 32'h44) begin errors++; $display("FAIL flush_next_data got %0h expected 44", a_out_data); end
    checks++; if (a_out_ctrl !== 8'h44) begin errors++; $display("FAIL flush_next_ctrl got %0h expected 44", a_out_ctrl); end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %0h expected 0", a_out_valid); end
  endtask

  task automatic test_bubble();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    a_in_ctrl   = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_ctrl !== 8'h00) begin errors++; $display("FAIL bubble_ctrl[%0d] got %0h expected 0", i, a_out_ctrl); end
    end
    a_in_valid = 1'b1;
    a_in_ctrl  = 8'h5A;
    tick();
    checks++; if (a_out_ctrl !== 8'h5A) begin errors++; $display("FAIL bubble_load got %0h expected 5a", a_out_ctrl); end
    a_in_valid = 1'b0;
    a_in_ctrl  = 8'hFF;
    tick();
    checks++; if (a_out_ctrl !== 8'h00) begin errors++; $display("FAIL bubble_after got %0h expected 0", a_out_ctrl); end
  endtask

  task automatic test_noskid();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = 32'(8'h20 + i);
      b_in_ctrl = 8'(8'h30 + i);
      tick();
      checks++; if (b_out_data !== 32'(8'h20 + i)) begin errors++; $display("FAIL noskid_data[%0d] got %0h expected %0h", i, b_out_data, 8'h20 + i); end
      checks++; if (b_out_ctrl !== 8'(8'h30 + i)) begin errors++; $display("FAIL noskid_ctrl[%0d] got %0h expected %0h", i, b_out_ctrl, 8'h30 + i); end
    end
    b_out_ready = 1'b0;
    b_in_data   = 32'h99;
    #1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_ready_comb got %0h expected 0", b_in_ready); end
    tick();
    checks++; if (b_out_data !== 32'h22) begin errors++; $display("FAIL noskid_hold got %0h expected 22", b_out_data); end
    b_out_ready = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_ready_back got %0h expected 1", b_in_ready); end
    tick();
    checks++; if (b_out_data !== 32'h99) begin errors++; $display("FAIL noskid_after got %0h expected 99", b_out_data); end
    b_in_valid  = 1'b0;
    tick();
    b_out_ready = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL noskid_empty got %0h expected 0", b_out_valid); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_ready_empty got %0h expected 1", b_in_ready); end
    checks++; if (b_stall_cnt !== 16'd1) begin errors++; $display("FAIL noskid_stall_cnt got %0d expected 1", b_stall_cnt); end
  endtask

  task automatic test_saturation_reset();
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_data   = 32'h77;
    c_in_ctrl   = 8'h3C;
    tick();
    c_in_valid  = 1'b0;
    c_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (c_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_cnt got %0d expected 15", c_stall_cnt); end
    checks++; if (c_out_data !== 32'h77) begin errors++; $display("FAIL sat_hold got %0h expected 77", c_out_data); end
    // Reset asserted between clock edges, mid-stall.
    #2;
    reset = 1'b0;
    #1;
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0h expected 0", c_out_valid); end
    checks++; if (c_out_ctrl !== 8'h00) begin errors++; $display("FAIL async_ctrl got %0h expected 0", c_out_ctrl); end
    checks++; if (c_out_data !== 32'h0) begin errors++; $display("FAIL async_data got %0h expected 0", c_out_data); end
    checks++; if (c_stall_cnt !== 4'd0) begin errors++; $display("FAIL async_stall_cnt got %0d expected 0", c_stall_cnt); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %0h expected 1", c_in_ready); end
    #1;
    reset = 1'b1;
    c_in_valid  = 1'b1;
    c_out_ready = 1'b1;
    c_in_data   = 32'h5;
    c_in_ctrl   = 8'h06;
    tick();
    checks++; if (c_out_data !== 32'h5) begin errors++; $display("FAIL first_after_reset got %0h expected 5", c_out_data); end
    checks++; if (c_out_ctrl !== 8'h06) begin errors++; $display("FAIL first_after_reset_ctrl got %0h expected 6", c_out_ctrl); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_ctrl = '0; c_in_data = '0;
    #2;
    reset = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    #2;
    reset = 1'b1;
    test_streaming();
    test_skid_capture();
    test_flush();
    test_bubble();
    test_noskid();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
